// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the core memory stage and the cpu_req/cpu_res port.
// Stores retire into a FIFO and drain in order; loads forward from the newest match or bypass the queue.
module mem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_valid,
    input  logic                     core_rw,
    input  logic [31:0]              core_addr,
    input  logic [31:0]              core_wdata,
    output logic                     core_stall,
    output logic [31:0]              core_rdata,
    output logic [26:0]              cpu_req_addr,
    output logic [31:0]              cpu_req_data,
    output logic                     cpu_req_rw,
    output logic                     cpu_req_valid,
    input  logic [31:0]              cpu_res_data,
    input  logic                     cpu_res_ready,
    output logic [$clog2(DEPTH):0]   sb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    state_t state, state_nxt;

    logic [24:0]   sb_widx [DEPTH];
    logic [31:0]   sb_data [DEPTH];
    logic [PW-1:0] head, tail, slot, st_slot;
    logic [24:0]   widx;
    logic          unused_addr;
    logic          fwd_hit, is_full, store_req, load_req, push, pop, done, load_miss, rd_done;
    logic [31:0]   fwd_data;
    logic          ld_rd, ld_wr, req_clr;

    assign widx        = core_addr[26:2];
    assign unused_addr = ^{core_addr[31:27], core_addr[1:0]};

    // Oldest-to-newest scan over occupied slots; a later match overrides, so the newest wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if ((CW'(i) < sb_count) && (sb_widx[slot] == widx)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[slot];
            end
        end
    end

    assign is_full    = (sb_count == CW'(DEPTH));
    assign store_req  = core_valid & core_rw;
    assign load_req   = core_valid & ~core_rw;
    assign push       = store_req & ~is_full;
    assign done       = cpu_req_valid & cpu_res_ready;
    assign load_miss  = load_req & ~fwd_hit;
    assign pop        = (state == WR) & done;
    assign rd_done    = (state == RD) & done;
    assign core_stall = (store_req & is_full) | (load_miss & ~rd_done);
    assign core_rdata = fwd_hit ? fwd_data : (rd_done ? cpu_res_data : 32'h0);

    // A pending load miss always wins over starting the next drain write.
    always_comb begin
        state_nxt = state;
        ld_rd     = 1'b0;
        ld_wr     = 1'b0;
        req_clr   = 1'b0;
        st_slot   = head;
        case (state)
            IDLE: begin
                if (load_miss) begin
                    state_nxt = RD;
                    ld_rd     = 1'b1;
                end else if (sb_count != '0) begin
                    state_nxt = WR;
                    ld_wr     = 1'b1;
                end
            end
            WR: begin
                if (done) begin
                    if (load_miss) begin
                        state_nxt = RD;
                        ld_rd     = 1'b1;
                    end else if (sb_count > CW'(1)) begin
                        state_nxt = WR;
                        ld_wr     = 1'b1;
                        st_slot   = head + PW'(1);
                    end else begin
                        state_nxt = IDLE;
                        req_clr   = 1'b1;
                    end
                end
            end
            RD: begin
                if (done) begin
                    state_nxt = IDLE;
                    req_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cpu_req_valid <= 1'b0;
            cpu_req_addr  <= '0;
            cpu_req_data  <= '0;
            cpu_req_rw    <= 1'b0;
            head          <= '0;
            tail          <= '0;
            sb_count      <= '0;
        end else begin
            state    <= state_nxt;
            sb_count <= sb_count + CW'(push) - CW'(pop);
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (ld_rd) begin
                cpu_req_valid <= 1'b1;
                cpu_req_rw    <= 1'b0;
                cpu_req_addr  <= {widx, 2'b00};
                cpu_req_data  <= '0;
            end else if (ld_wr) begin
                cpu_req_valid <= 1'b1;
                cpu_req_rw    <= 1'b1;
                cpu_req_addr  <= {sb_widx[st_slot], 2'b00};
                cpu_req_data  <= sb_data[st_slot];
            end else if (req_clr) begin
                cpu_req_valid <= 1'b0;
            end
        end
    end

    // Entry storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_widx[tail] <= widx;
            sb_data[tail] <= core_wdata;
        end
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: full stall, forwarding, load bypass ordering,
// long sequential store/load traffic with a random-latency memory, and mid-operation reset.
module tb_mem_store_buffer;
    logic        clk;
    logic        rst;
    logic        core_valid, core_rw;
    logic [31:0] core_addr, core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic [26:0] cpu_req_addr;
    logic [31:0] cpu_req_data;
    logic        cpu_req_rw, cpu_req_valid;
    logic [31:0] cpu_res_data;
    logic        cpu_res_ready;
    logic [2:0]  sb_count;

    int checks = 0;
    int errors = 0;

    logic        auto_mem, man_ready, rand_lat;
    int          fixed_lat;
    logic        model_ready;
    logic [31:0] model_data;
    int          wait_cnt, cur_rand, log_n;
    logic [31:0] mem_model [0:2047];
    logic [27:0] log_mem   [0:15];

    mem_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_rw(core_rw), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_req_rw(cpu_req_rw), .cpu_req_valid(cpu_req_valid),
        .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
        .sb_count(sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cpu_res_ready = auto_mem ? model_ready : man_ready;
    assign cpu_res_data  = auto_mem ? model_data  : 32'h0;

    // Memory model: ready rises after the configured wait, completion applies writes and logs order.
    always @(posedge clk) begin
        if (rst) begin
            model_ready <= 1'b0;
            model_data  <= 32'h0;
            wait_cnt    <= 0;
            cur_rand    <= 0;
            log_n       <= 0;
            for (int i = 0; i < 2048; i++) mem_model[i] <= 32'h0;
            mem_model[64] <= 32'hDEADBEEF;
        end else if (auto_mem && cpu_req_valid) begin
            if (model_ready) begin
                if (cpu_req_rw) mem_model[cpu_req_addr[12:2]] <= cpu_req_data;
                if (log_n < 16) begin
                    log_mem[log_n] <= {cpu_req_rw, cpu_req_addr};
                    log_n <= log_n + 1;
                end
                model_ready <= 1'b0;
                wait_cnt    <= 0;
                cur_rand    <= int'($urandom_range(0, 3));
            end else if (wait_cnt >= (rand_lat ? cur_rand : fixed_lat)) begin
                model_ready <= 1'b1;
                model_data  <= mem_model[cpu_req_addr[12:2]];
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            model_ready <= 1'b0;
            wait_cnt    <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one op, holds it through any stall, returns stall cycles and the load data.
    task automatic op(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                      output int stalls, output logic [31:0] rdata);
        core_valid = 1'b1;
        core_rw    = rw;
        core_addr  = addr;
        core_wdata = wdata;
        stalls     = 0;
        #1;
        while (core_stall && stalls < 1000) begin
            tick();
            stalls++;
        end
        if (stalls >= 1000) begin
            checks++;
            errors++;
            $error("FAIL op_timeout observed=stalled expected=completion addr=%h", addr);
        end
        rdata = core_rdata;
        tick();
        core_valid = 1'b0;
    endtask

    initial begin
        int          st, n;
        logic [31:0] rd;
        core_valid = 1'b0; core_rw = 1'b0; core_addr = '0; core_wdata = '0;
        auto_mem = 1'b0; man_ready = 1'b0; rand_lat = 1'b0; fixed_lat = 0;
        rst = 1'b0;

        // Reset state
        do_reset();
        #1;
        check("rst_valid", {31'b0, cpu_req_valid}, 32'd0);
        check("rst_count", {29'b0, sb_count}, 32'd0);
        check("rst_stall", {31'b0, core_stall}, 32'd0);
        check("rst_rdata", core_rdata, 32'd0);
        check("rst_addr",  {5'b0, cpu_req_addr}, 32'd0);
        check("rst_rw",    {31'b0, cpu_req_rw}, 32'd0);

        // Four stores with memory never ready: no stalls, buffer fills
        for (int i = 0; i < 4; i++) begin
            op(1'b1, (32'h10 + i) << 2, 32'hA0 + i, st, rd);
            check("fill_stall", st, 32'd0);
        end
        #1;
        check("fill_count", {29'b0, sb_count}, 32'd4);
        check("fill_req_valid", {31'b0, cpu_req_valid}, 32'd1);
        check("fill_req_addr", {5'b0, cpu_req_addr}, 32'h40);
        check("fill_req_data", cpu_req_data, 32'hA0);
        check("fill_req_rw", {31'b0, cpu_req_rw}, 32'd1);
        // Fifth store: stalls while full, including the cycle of the head completion
        core_valid = 1'b1; core_rw = 1'b1; core_addr = 32'h14 << 2; core_wdata = 32'hA4;
        #1;
        check("full_stall", {31'b0, core_stall}, 32'd1);
        tick();
        man_ready = 1'b1;
        #1;
        check("full_stall_pop_cycle", {31'b0, core_stall}, 32'd1);
        tick();
        man_ready = 1'b0;
        #1;
        check("after_pop_stall", {31'b0, core_stall}, 32'd0);
        check("after_pop_count", {29'b0, sb_count}, 32'd3);
        check("wr_wr_addr", {5'b0, cpu_req_addr}, 32'h44);
        check("wr_wr_data", cpu_req_data, 32'hA1);
        tick();
        core_valid = 1'b0;
        #1;
        check("accept5_count", {29'b0, sb_count}, 32'd4);

        // Forwarding picks the newest of two stores to the same word
        do_reset();
        op(1'b1, 32'h10 << 2, 32'h11, st, rd);
        op(1'b1, 32'h10 << 2, 32'h22, st, rd);
        core_valid = 1'b1; core_rw = 1'b0; core_addr = 32'h10 << 2;
        #1;
        check("fwd_stall", {31'b0, core_stall}, 32'd0);
        check("fwd_rdata", core_rdata, 32'h22);
        check("fwd_count", {29'b0, sb_count}, 32'd2);
        tick();
        core_valid = 1'b0;

        // Load miss bypasses queued stores once the in-flight store completes
        do_reset();
        auto_mem = 1'b1; fixed_lat = 2;
        op(1'b1, 32'h20 << 2, 32'd1, st, rd);
        op(1'b1, 32'h21 << 2, 32'd2, st, rd);
        op(1'b1, 32'h22 << 2, 32'd3, st, rd);
        op(1'b0, 32'h40 << 2, 32'd0, st, rd);
        check("miss_rdata", rd, 32'hDEADBEEF);
        n = 0;
        while (sb_count != 3'd0 && n < 200) begin
            tick();
            n++;
        end
        check("miss_drain_count", {29'b0, sb_count}, 32'd0);
        check("order_n", log_n, 32'd4);
        check("order_0", {4'b0, log_mem[0]}, {4'b0, 1'b1, 27'h80});
        check("order_1", {4'b0, log_mem[1]}, {4'b0, 1'b0, 27'h100});
        check("order_2", {4'b0, log_mem[2]}, {4'b0, 1'b1, 27'h84});
        check("order_3", {4'b0, log_mem[3]}, {4'b0, 1'b1, 27'h88});

        // Long run with random latency: pointers wrap many times
        rand_lat = 1'b1;
        for (int i = 0; i < 1024; i++) op(1'b1, i << 2, i, st, rd);
        for (int i = 0; i < 1024; i++) begin
            op(1'b0, i << 2, 32'd0, st, rd);
            check("seq_load", rd, i);
        end

        // Reset while a write is in flight with three entries buffered
        auto_mem = 1'b0; rand_lat = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) op(1'b1, (32'h30 + i) << 2, 32'hC0 + i, st, rd);
        #1;
        check("pre_rst_count", {29'b0, sb_count}, 32'd3);
        check("pre_rst_valid", {31'b0, cpu_req_valid}, 32'd1);
        rst = 1'b1;
        tick();
        #1;
        check("mid_rst_valid", {31'b0, cpu_req_valid}, 32'd0);
        check("mid_rst_count", {29'b0, sb_count}, 32'd0);
        check("mid_rst_stall", {31'b0, core_stall}, 32'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
